dac_write_scheduler: RTL

DAC_WRITE_SCHEDULER -- requirements
Module: dac_write_scheduler

---
 rtl/Subsystem_pkg.sv | 24 ++
 rtl/dac_write_scheduler_if.sv | 26 ++
 rtl/dac_write_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/Subsystem_pkg.sv
// Shared types and default timing for the DAC write scheduler.
// Phase lengths are in clk_in cycles; the state enum is the scheduler's phase list.
package Subsystem_pkg;

  typedef logic signed [11:0] vector_of_signed_logic_12;

  localparam int unsigned N_CHANNELS            = 8;
  localparam int unsigned N_SLOTS               = 4;
  localparam int unsigned SETUP_CYCLES_DEFAULT  = 8;
  localparam int unsigned STROBE_CYCLES_DEFAULT = 4;
  localparam int unsigned HOLD_CYCLES_DEFAULT   = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP_B,
    STROBE_B,
    HOLD_B,
    SETUP_A,
    STROBE_A,
    HOLD_A,
    DONE
  } sched_state_e;

endpackage

// File: rtl/dac_write_scheduler_if.sv
// Request/data bundle between a DAC sequencer client and the write scheduler.
// slave = scheduler side, master = requester side.
interface dac_write_scheduler_if;
  import Subsystem_pkg::*;

  logic                     start;
  logic                     wr_enable;
  vector_of_signed_logic_12 DAC_out [0:N_CHANNELS-1];
  vector_of_signed_logic_12 DAC_out_4_slots [0:N_SLOTS-1];
  logic [7:0]               wr_ch0;
  logic [7:0]               wr_ch1;
  logic                     busy;
  logic                     done;
  logic [7:0]               drop_count;

  modport slave (
    input  start, wr_enable, DAC_out,
    output DAC_out_4_slots, wr_ch0, wr_ch1, busy, done, drop_count
  );

  modport master (
    output start, wr_enable, DAC_out,
    input  DAC_out_4_slots, wr_ch0, wr_ch1, busy, done, drop_count
  );

endinterface

// File: rtl/dac_write_scheduler.sv
// Writes 8 DAC channels over a 4-slot bus: odd bank (wr_ch1) then even bank (wr_ch0), setup/strobe/hold each.
// Outputs registered, sequence is 2*(S+T+H)+1 cycles; one start queues while busy, further starts count as drops.
module dac_write_scheduler
  import Subsystem_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = SETUP_CYCLES_DEFAULT,
  parameter int unsigned STROBE_CYCLES = STROBE_CYCLES_DEFAULT,
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEFAULT
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  dac_write_scheduler_if.slave  bus
);

  sched_state_e             state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     pending_q, pending_d;
  logic [7:0]               drop_q, drop_d;
  logic                     take_snap;
  logic                     drop_req;
  logic                     enter_a;
  vector_of_signed_logic_12 snap_q [0:N_CHANNELS-1];
  logic                     snap_en_q;
  vector_of_signed_logic_12 slots_q [0:N_SLOTS-1];
  logic [7:0]               wr_ch0_q, wr_ch1_q;
  logic                     busy_q, done_q;

  function automatic logic [7:0] phase_reload(sched_state_e s);
    case (s)
      SETUP_B, SETUP_A:   phase_reload = 8'(SETUP_CYCLES - 1);
      STROBE_B, STROBE_A: phase_reload = 8'(STROBE_CYCLES - 1);
      HOLD_B, HOLD_A:     phase_reload = 8'(HOLD_CYCLES - 1);
      default:            phase_reload = 8'd0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    take_snap = 1'b0;
    drop_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SETUP_B;
          take_snap = 1'b1;
        end
      end
      DONE: begin
        // A queued start, or one arriving now, is serviced without dropping busy.
        if (pending_q || bus.start) begin
          state_d   = SETUP_B;
          take_snap = 1'b1;
          pending_d = pending_q && bus.start;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        if (cnt_q == 8'd0) begin
          case (state_q)
            SETUP_B:  state_d = STROBE_B;
            STROBE_B: state_d = HOLD_B;
            HOLD_B:   state_d = SETUP_A;
            SETUP_A:  state_d = STROBE_A;
            STROBE_A: state_d = HOLD_A;
            default:  state_d = DONE;
          endcase
        end
        if (bus.start) begin
          if (!pending_q) pending_d = 1'b1;
          else            drop_req  = 1'b1;
        end
      end
    endcase
    if (drop_req && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    if (state_d != state_q || take_snap) cnt_d = phase_reload(state_d);
    else if (cnt_q != 8'd0)              cnt_d = cnt_q - 8'd1;
  end

  assign enter_a = (state_q == HOLD_B) && (state_d == SETUP_A);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      pending_q <= 1'b0;
      drop_q    <= 8'd0;
      snap_en_q <= 1'b0;
      wr_ch0_q  <= 8'h00;
      wr_ch1_q  <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < N_CHANNELS; i++) snap_q[i] <= '0;
      for (int i = 0; i < N_SLOTS; i++)    slots_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      wr_ch1_q  <= (state_d == STROBE_B && snap_en_q) ? 8'hFF : 8'h00;
      wr_ch0_q  <= (state_d == STROBE_A && snap_en_q) ? 8'hFF : 8'h00;
      if (take_snap) begin
        snap_en_q <= bus.wr_enable;
        for (int i = 0; i < N_CHANNELS; i++) snap_q[i] <= bus.DAC_out[i];
        // Odd bank goes out first, straight from the inputs being snapshotted.
        for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= bus.DAC_out[2*i+1];
      end else if (enter_a) begin
        for (int i = 0; i < N_SLOTS; i++) slots_q[i] <= snap_q[2*i];
      end
    end
  end

  assign bus.DAC_out_4_slots = slots_q;
  assign bus.wr_ch0          = wr_ch0_q;
  assign bus.wr_ch1          = wr_ch1_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.drop_count      = drop_q;

endmodule
